// File: rtl/instruction_fetcher_pkg.sv
// Shared widths, cache geometry and fetcher state encodings for the IF stage.
package instruction_fetcher_pkg;

    localparam int unsigned InstBus      = 32;
    localparam int unsigned AddressBus   = 32;
    localparam int unsigned ICacheIdxBus = 8;
    localparam int unsigned ICacheTagBus = AddressBus - ICacheIdxBus - 2;
    localparam int unsigned ICacheLines  = 1 << ICacheIdxBus;

    localparam logic               Valid = 1'b1;
    localparam logic [InstBus-1:0] Null  = '0;

    typedef enum logic [0:0] {
        IFIdle,
        IFWait
    } if_state_e;

endpackage

// File: rtl/instruction_fetcher_if.sv
// IF-side bundle: push port into the instruction queue plus the miss port to memory.
interface instruction_fetcher_if;
    import instruction_fetcher_pkg::*;

    logic                  IF_inst_valid;
    logic [InstBus-1:0]    IF_inst;
    logic [AddressBus-1:0] IF_pc;
    logic                  queue_is_full;

    logic                  mem_req;
    logic [AddressBus-1:0] mem_addr;
    logic                  mem_done;
    logic [InstBus-1:0]    mem_data;

    modport master (
        output IF_inst_valid, IF_inst, IF_pc, mem_req, mem_addr,
        input  queue_is_full, mem_done, mem_data
    );

    modport slave (
        input  IF_inst_valid, IF_inst, IF_pc, mem_req, mem_addr,
        output queue_is_full, mem_done, mem_data
    );

endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache: combinational lookup,
// synchronous fill, invalidate-all on reset.
module icache_dm
    import instruction_fetcher_pkg::*;
#(
    parameter int unsigned IDX_BITS = ICacheIdxBus,
    parameter int unsigned LINES    = ICacheLines,
    parameter int unsigned TAG_BITS = ICacheTagBus
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AddressBus-1:2]   lookup_waddr,
    output logic                    hit,
    output logic [InstBus-1:0]      rd_data,
    input  logic                    fill_en,
    input  logic [AddressBus-1:2]   fill_waddr,
    input  logic [InstBus-1:0]      fill_data
);

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [InstBus-1:0]  data_q [LINES];

    logic [IDX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_BITS-1:0] rd_tag, wr_tag;

    assign rd_idx = lookup_waddr[IDX_BITS+1:2];
    assign rd_tag = lookup_waddr[AddressBus-1:IDX_BITS+2];
    assign wr_idx = fill_waddr[IDX_BITS+1:2];
    assign wr_tag = fill_waddr[AddressBus-1:IDX_BITS+2];

    assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data = data_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[wr_idx] <= Valid;
        end
    end

    // Tag/data need no reset; valid bits gate every read.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: owns the fetch PC, pushes {inst, pc} into the instruction queue and
// refills the direct-mapped I-cache from memory on a miss.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int unsigned           ICACHE_INDEX_BITS = ICacheIdxBus,
    parameter logic [AddressBus-1:0] RESET_PC          = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clear,
    input  logic [AddressBus-1:0] clear_pc,
    instruction_fetcher_if.master bus
);

    if_state_e             state_q, state_d;
    logic [AddressBus-1:0] pc_q, pc_d;
    logic                  inst_valid_q, inst_valid_d;
    logic [InstBus-1:0]    inst_q, inst_d;
    logic [AddressBus-1:0] if_pc_q, if_pc_d;
    logic                  req_q, req_d;
    logic [AddressBus-1:0] addr_q, addr_d;

    logic                  hit;
    logic [InstBus-1:0]    line_data;
    logic                  fill_en;
    logic [AddressBus-1:0] clear_target;
    logic                  unused_clear_lsb;

    assign clear_target     = {clear_pc[AddressBus-1:2], 2'b00};
    assign unused_clear_lsb = ^clear_pc[1:0];
    // A fill completes even across a redirect: instruction memory is static.
    assign fill_en          = rdy && (state_q == IFWait) && bus.mem_done;

    icache_dm #(
        .IDX_BITS (ICACHE_INDEX_BITS),
        .LINES    (1 << ICACHE_INDEX_BITS),
        .TAG_BITS (AddressBus - 2 - ICACHE_INDEX_BITS)
    ) u_icache (
        .clk          (clk),
        .rst          (rst),
        .lookup_waddr (pc_q[AddressBus-1:2]),
        .hit          (hit),
        .rd_data      (line_data),
        .fill_en      (fill_en),
        .fill_waddr   (addr_q[AddressBus-1:2]),
        .fill_data    (bus.mem_data)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = 1'b0;
        inst_d       = inst_q;
        if_pc_d      = if_pc_q;
        req_d        = req_q;
        addr_d       = addr_q;
        unique case (state_q)
            IFIdle: begin
                if (clear) begin
                    pc_d = clear_target;
                end else if (hit) begin
                    if (!bus.queue_is_full) begin
                        inst_valid_d = 1'b1;
                        inst_d       = line_data;
                        if_pc_d      = pc_q;
                        pc_d         = pc_q + 32'd4;
                    end
                end else begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = IFWait;
                end
            end
            IFWait: begin
                if (bus.mem_done) begin
                    req_d   = 1'b0;
                    state_d = IFIdle;
                end
                if (clear) begin
                    pc_d = clear_target;
                end
            end
            default: state_d = IFIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IFIdle;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= Null;
            if_pc_q      <= '0;
            req_q        <= 1'b0;
            addr_q       <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            if_pc_q      <= if_pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
        end
    end

    assign bus.IF_inst_valid = inst_valid_q;
    assign bus.IF_inst       = inst_q;
    assign bus.IF_pc         = if_pc_q;
    assign bus.mem_req       = req_q;
    assign bus.mem_addr      = addr_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: a budgeted memory responder plus push and
// request logs sampled on the falling edge.
module tb_instruction_fetcher;

    localparam int MemLat = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic [31:0] clear_pc;

    instruction_fetcher_if bus ();

    instruction_fetcher #(
        .ICACHE_INDEX_BITS (8),
        .RESET_PC          (32'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .clear    (clear),
        .clear_pc (clear_pc),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int resp_budget = 0;
    int wait_cnt = 0;

    logic [31:0] push_pc[$];
    logic [31:0] push_inst[$];
    int          push_cyc[$];
    logic [31:0] req_log[$];
    logic        req_seen = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory: answers MemLat cycles after seeing mem_req, only while budget remains.
    initial begin
        bus.mem_done = 1'b0;
        bus.mem_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_done = 1'b0;
            if (!rst && rdy && bus.mem_req && resp_budget > 0) begin
                if (wait_cnt >= MemLat - 1) begin
                    bus.mem_done = 1'b1;
                    bus.mem_data = mem_word(bus.mem_addr);
                    wait_cnt     = 0;
                    resp_budget--;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Queue-side view: a push counts once, at an edge where rdy is high.
    initial forever begin
        @(negedge clk);
        if (!rst && rdy) begin
            if (bus.IF_inst_valid) begin
                push_pc.push_back(bus.IF_pc);
                push_inst.push_back(bus.IF_inst);
                push_cyc.push_back(cyc);
            end
            if (bus.mem_req && !req_seen) req_log.push_back(bus.mem_addr);
            req_seen = bus.mem_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear(input logic [31:0] target);
        clear    = 1'b1;
        clear_pc = target;
        tick();
        clear    = 1'b0;
    endtask

    task automatic wait_reqs(input int n, output bit ok);
        for (int i = 0; i < 80; i++) begin
            if (req_log.size() >= n) break;
            tick();
        end
        ok = (req_log.size() >= n);
    endtask

    task automatic clear_pushes();
        push_pc.delete();
        push_inst.delete();
        push_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; clear_pc = 32'h0;
        bus.queue_is_full = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (bus.IF_inst_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %b want 0", bus.IF_inst_valid);
        end
        n_checks++;
        if (bus.IF_inst !== 32'h0) begin
            n_errors++; $display("FAIL reset_inst: got %h want 0", bus.IF_inst);
        end
        n_checks++;
        if (bus.IF_pc !== 32'h0) begin
            n_errors++; $display("FAIL reset_pc: got %h want 0", bus.IF_pc);
        end
        n_checks++;
        if (bus.mem_req !== 1'b0) begin
            n_errors++; $display("FAIL reset_req: got %b want 0", bus.mem_req);
        end
        n_checks++;
        if (bus.mem_addr !== 32'h0) begin
            n_errors++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr);
        end
    endtask

    // Cold start: lines 0..12 filled one miss at a time, then stuck waiting on 16.
    task automatic test_first_miss();
        bit ok;
        resp_budget = 4;
        rst = 1'b0;
        wait_reqs(5, ok);
        n_checks++;
        if (!ok) begin
            n_errors++; $display("FAIL first_miss_timeout: got %0d reqs want 5", req_log.size());
        end
        n_checks++;
        if (req_log[0] !== 32'h0) begin
            n_errors++; $display("FAIL first_req_addr: got %h want 0", req_log[0]);
        end
        n_checks++;
        if (push_pc[0] !== 32'h0) begin
            n_errors++; $display("FAIL first_push_pc: got %h want 0", push_pc[0]);
        end
        n_checks++;
        if (push_inst[0] !== 32'h0000_0013) begin
            n_errors++; $display("FAIL first_push_inst: got %h want 00000013", push_inst[0]);
        end
        n_checks++;
        if (req_log[1] !== 32'h4) begin
            n_errors++; $display("FAIL second_req_addr: got %h want 4", req_log[1]);
        end
        n_checks++;
        if (push_pc.size() !== 4) begin
            n_errors++; $display("FAIL first_push_count: got %0d want 4", push_pc.size());
        end
    endtask

    task automatic test_hit_stream();
        bit ok;
        int base;
        clear_pushes();
        base = req_log.size();
        pulse_clear(32'h0);
        resp_budget = 1;
        wait_reqs(base + 1, ok);
        n_checks++;
        if (!ok || req_log[base] !== 32'h14) begin
            n_errors++; $display("FAIL stream_next_req: got %h want 00000014", req_log[base]);
        end
        n_checks++;
        if (push_pc.size() !== 5) begin
            n_errors++; $display("FAIL stream_count: got %0d want 5", push_pc.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (push_pc[i] !== 32'(i * 4) || push_inst[i] !== mem_word(32'(i * 4))) begin
                n_errors++;
                $display("FAIL stream_push%0d: got pc %h inst %h want pc %h inst %h", i,
                         push_pc[i], push_inst[i], 32'(i * 4), mem_word(32'(i * 4)));
            end
        end
        n_checks++;
        if (push_cyc[3] - push_cyc[0] !== 3) begin
            n_errors++; $display("FAIL stream_rate: got %0d cycles want 3", push_cyc[3] - push_cyc[0]);
        end
    endtask

    task automatic test_queue_full();
        bit ok;
        int base;
        clear_pushes();
        base = req_log.size();
        pulse_clear(32'h0);
        resp_budget = 1;
        for (int i = 0; i < 40; i++) begin
            if (push_pc.size() >= 2) break;
            tick();
        end
        n_checks++;
        if (push_pc.size() < 2) begin
            n_errors++; $display("FAIL full_start_timeout: got %0d pushes want 2", push_pc.size());
        end
        bus.queue_is_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.IF_inst_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
                n_errors++;
                $display("FAIL full_hold%0d: got valid %b req %b want 0 0", i,
                         bus.IF_inst_valid, bus.mem_req);
            end
        end
        bus.queue_is_full = 1'b0;
        wait_reqs(base + 1, ok);
        n_checks++;
        if (!ok || req_log[base] !== 32'h18) begin
            n_errors++; $display("FAIL full_next_req: got %h want 00000018", req_log[base]);
        end
        n_checks++;
        if (push_pc.size() !== 6) begin
            n_errors++; $display("FAIL full_count: got %0d want 6", push_pc.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (push_pc[i] !== 32'(i * 4)) begin
                n_errors++; $display("FAIL full_seq%0d: got %h want %h", i, push_pc[i], 32'(i * 4));
            end
        end
        n_checks++;
        if (push_cyc[3] - push_cyc[2] !== 4) begin
            n_errors++; $display("FAIL full_gap: got %0d want 4", push_cyc[3] - push_cyc[2]);
        end
    endtask

    task automatic test_clear_in_wait();
        bit ok;
        int base;
        clear_pushes();
        base = req_log.size();
        pulse_clear(32'h408);
        resp_budget = 1;
        wait_reqs(base + 1, ok);
        n_checks++;
        if (!ok || req_log[base] !== 32'h408) begin
            n_errors++; $display("FAIL redirect_req: got %h want 00000408", req_log[base]);
        end
        // Redirect while waiting on 0x408; clear_pc low bits must be dropped.
        pulse_clear(32'h1003);
        resp_budget = 1;
        wait_reqs(base + 2, ok);
        n_checks++;
        if (!ok || req_log[base + 1] !== 32'h1000) begin
            n_errors++; $display("FAIL wait_clear_req: got %h want 00001000", req_log[base + 1]);
        end
        n_checks++;
        if (push_pc.size() !== 0) begin
            n_errors++; $display("FAIL wait_clear_nopush: got %0d pushes want 0", push_pc.size());
        end
        pulse_clear(32'h408);
        resp_budget = 1;
        wait_reqs(base + 3, ok);
        n_checks++;
        if (!ok || req_log[base + 2] !== 32'h40c) begin
            n_errors++; $display("FAIL line2_filled_req: got %h want 0000040c", req_log[base + 2]);
        end
        n_checks++;
        if (push_pc.size() !== 1 || push_pc[0] !== 32'h408 || push_inst[0] !== 32'h0408_0013) begin
            n_errors++;
            $display("FAIL line2_filled_push: got n %0d pc %h inst %h want 1 408 04080013",
                     push_pc.size(), push_pc[0], push_inst[0]);
        end
    endtask

    task automatic test_eviction();
        bit ok;
        int base;
        clear_pushes();
        base = req_log.size();
        pulse_clear(32'h0);
        resp_budget = 1;
        wait_reqs(base + 1, ok);
        resp_budget = 1;
        wait_reqs(base + 2, ok);
        n_checks++;
        if (!ok || req_log[base] !== 32'h0 || req_log[base + 1] !== 32'h8) begin
            n_errors++;
            $display("FAIL evict_setup: got %h %h want 0 8", req_log[base], req_log[base + 1]);
        end
        pulse_clear(32'h400);
        resp_budget = 1;
        wait_reqs(base + 3, ok);
        n_checks++;
        if (!ok || req_log[base + 2] !== 32'h400) begin
            n_errors++; $display("FAIL evict_alias_req: got %h want 00000400", req_log[base + 2]);
        end
        resp_budget = 1;
        wait_reqs(base + 4, ok);
        n_checks++;
        if (!ok || req_log[base + 3] !== 32'h404) begin
            n_errors++; $display("FAIL evict_next_req: got %h want 00000404", req_log[base + 3]);
        end
        n_checks++;
        if (push_pc.size() !== 3 || push_pc[2] !== 32'h400) begin
            n_errors++;
            $display("FAIL evict_pushes: got n %0d last %h want 3 400", push_pc.size(), push_pc[2]);
        end
        pulse_clear(32'h0);
        resp_budget = 1;
        wait_reqs(base + 5, ok);
        n_checks++;
        if (!ok || req_log[base + 4] !== 32'h0) begin
            n_errors++; $display("FAIL evict_refetch: got %h want 0", req_log[base + 4]);
        end
    endtask

    task automatic test_rdy_freeze();
        bit ok;
        int base;
        int zero_pushes;
        clear_pushes();
        base = req_log.size();
        resp_budget = 1;
        for (int i = 0; i < 40; i++) begin
            if (bus.IF_inst_valid === 1'b1) break;
            tick();
        end
        n_checks++;
        if (bus.IF_inst_valid !== 1'b1) begin
            n_errors++; $display("FAIL freeze_push_timeout: got valid %b want 1", bus.IF_inst_valid);
        end
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (bus.IF_inst_valid !== 1'b1 || bus.IF_pc !== 32'h0 ||
                bus.IF_inst !== 32'h13 || bus.mem_req !== 1'b0) begin
                n_errors++;
                $display("FAIL freeze_hold%0d: got valid %b pc %h inst %h req %b want 1 0 13 0", i,
                         bus.IF_inst_valid, bus.IF_pc, bus.IF_inst, bus.mem_req);
            end
        end
        rdy = 1'b1;
        wait_reqs(base + 1, ok);
        n_checks++;
        if (!ok || req_log[base] !== 32'h4) begin
            n_errors++; $display("FAIL freeze_next_req: got %h want 4", req_log[base]);
        end
        zero_pushes = 0;
        foreach (push_pc[i]) if (push_pc[i] === 32'h0) zero_pushes++;
        n_checks++;
        if (zero_pushes !== 1 || push_pc.size() !== 1) begin
            n_errors++;
            $display("FAIL freeze_once: got %0d pushes of pc 0 (%0d total) want 1 (1)",
                     zero_pushes, push_pc.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_hit_stream();
        test_queue_full();
        test_clear_in_wait();
        test_eviction();
        test_rdy_freeze();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
